memory_arbiter: RTL and testbench

- Shares one single-port synchronous-write / combinational-read memory between two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
- Uses round-robin arbitration with one accepted access per cycle.
- Registers read data, so the response arrives exactly one cycle after acceptance.
- Sits between the requesters and the memory instance; owns all memory address, write-enable and write-data pins.

---
 rtl/memory_arbiter_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Port index, response-stage bundle, port count.
package memory_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic port_idx_t;

  typedef struct packed {
    logic      Valid;
    port_idx_t PortIdx;
    logic      IsWrite;
  } rsp_stage_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker.
// i_Req/i_LastGrant in; o_Gnt/o_GntIdx/o_AnyGnt out.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_Req,
  input  port_idx_t            i_LastGrant,
  output logic [NUM_PORTS-1:0] o_Gnt,
  output port_idx_t            o_GntIdx,
  output logic                 o_AnyGnt
);

  port_idx_t idx;

  always_comb begin
    idx = 1'b0;
    unique case (1'b1)
      (i_Req == 2'b11): idx = ~i_LastGrant;
      (i_Req == 2'b10): idx = 1'b1;
      default:          idx = 1'b0;
    endcase
  end

  assign o_AnyGnt = |i_Req;
  assign o_GntIdx = idx;

  always_comb begin
    o_Gnt = '0;
    if (o_AnyGnt) begin
      o_Gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory between two requesters.
// Req/Addr/WrEnable/WrData in per port; Ready/RspValid/RdData out; Mem* pins.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Req0,
  input  logic [ADDR_WIDTH-1:0] i_Addr0,
  input  logic                  i_WrEnable0,
  input  logic [DATA_WIDTH-1:0] i_WrData0,
  input  logic                  i_Req1,
  input  logic [ADDR_WIDTH-1:0] i_Addr1,
  input  logic                  i_WrEnable1,
  input  logic [DATA_WIDTH-1:0] i_WrData1,
  output logic                  o_Ready0,
  output logic                  o_Ready1,
  output logic                  o_RspValid0,
  output logic                  o_RspValid1,
  output logic [DATA_WIDTH-1:0] o_RdData0,
  output logic [DATA_WIDTH-1:0] o_RdData1,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemWrEnable,
  output logic [DATA_WIDTH-1:0] o_MemWrData,
  input  logic [DATA_WIDTH-1:0] i_MemRdData
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt_raw;
  logic [NUM_PORTS-1:0] gnt;
  port_idx_t            gnt_idx;
  logic                 any_raw;
  logic                 any_gnt;

  port_idx_t  last_grant_q, last_grant_d;
  rsp_stage_t rsp_q, rsp_d;

  // Shared capture of the accepted read; per-port hold keeps it afterwards.
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
  logic [DATA_WIDTH-1:0] rd_hold0_q, rd_hold0_d;
  logic [DATA_WIDTH-1:0] rd_hold1_q, rd_hold1_d;

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_rsp0;
  logic                  rd_rsp1;

  assign req = {i_Req1, i_Req0};

  rr_arbiter2 u_arb (
    .i_Req       (req),
    .i_LastGrant (last_grant_q),
    .o_Gnt       (gnt_raw),
    .o_GntIdx    (gnt_idx),
    .o_AnyGnt    (any_raw)
  );

  // No grant can escape while reset is held low.
  assign gnt     = gnt_raw & {NUM_PORTS{i_Reset}};
  assign any_gnt = any_raw & i_Reset;

  assign o_Ready0 = gnt[0];
  assign o_Ready1 = gnt[1];

  assign sel_wr    = gnt_idx ? i_WrEnable1 : i_WrEnable0;
  assign sel_addr  = gnt_idx ? i_Addr1 : i_Addr0;
  assign sel_wdata = gnt_idx ? i_WrData1 : i_WrData0;

  always_comb begin
    o_MemAddr     = '0;
    o_MemWrEnable = 1'b0;
    o_MemWrData   = '0;
    if (any_gnt) begin
      o_MemAddr     = sel_addr;
      o_MemWrEnable = sel_wr;
      o_MemWrData   = sel_wdata;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (any_gnt) begin
      last_grant_d = gnt_idx;
    end
  end

  always_comb begin
    rsp_d.Valid   = any_gnt;
    rsp_d.PortIdx = gnt_idx;
    rsp_d.IsWrite = sel_wr;
  end

  assign rd_rsp0 = rsp_q.Valid & ~rsp_q.IsWrite
                 & (rsp_q.PortIdx == 1'b0);
  assign rd_rsp1 = rsp_q.Valid & ~rsp_q.IsWrite
                 & (rsp_q.PortIdx == 1'b1);

  always_comb begin
    rd_buf_d   = rd_buf_q;
    rd_hold0_d = rd_hold0_q;
    rd_hold1_d = rd_hold1_q;
    if (any_gnt && !sel_wr) begin
      rd_buf_d = i_MemRdData;
    end
    if (rd_rsp0) begin
      rd_hold0_d = rd_buf_q;
    end
    if (rd_rsp1) begin
      rd_hold1_d = rd_buf_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      last_grant_q <= 1'b1;
      rsp_q        <= '0;
      rd_buf_q     <= '0;
      rd_hold0_q   <= '0;
      rd_hold1_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_q        <= rsp_d;
      rd_buf_q     <= rd_buf_d;
      rd_hold0_q   <= rd_hold0_d;
      rd_hold1_q   <= rd_hold1_d;
    end
  end

  assign o_RspValid0 = rsp_q.Valid & (rsp_q.PortIdx == 1'b0);
  assign o_RspValid1 = rsp_q.Valid & (rsp_q.PortIdx == 1'b1);

  // Fresh read data comes straight from the capture register.
  assign o_RdData0 = rd_rsp0 ? rd_buf_q : rd_hold0_q;
  assign o_RdData1 = rd_rsp1 ? rd_buf_q : rd_hold1_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural memory.
// Checks grants, responses, read data, reset and idle behaviour.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [11:0] addr0, addr1;
  logic        we0, we1;
  logic [31:0] wd0, wd1;
  logic        rdy0, rdy1;
  logic        rv0, rv1;
  logic [31:0] rd0, rd1;
  logic [11:0] maddr;
  logic        mwe;
  logic [31:0] mwd;
  logic [31:0] mrd;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mwe) mem[maddr] <= mwd;
  end
  assign mrd = mem[maddr];

  memory_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst_n),
    .i_Req0        (req0),
    .i_Addr0       (addr0),
    .i_WrEnable0   (we0),
    .i_WrData0     (wd0),
    .i_Req1        (req1),
    .i_Addr1       (addr1),
    .i_WrEnable1   (we1),
    .i_WrData1     (wd1),
    .o_Ready0      (rdy0),
    .o_Ready1      (rdy1),
    .o_RspValid0   (rv0),
    .o_RspValid1   (rv1),
    .o_RdData0     (rd0),
    .o_RdData1     (rd1),
    .o_MemAddr     (maddr),
    .o_MemWrEnable (mwe),
    .o_MemWrData   (mwd),
    .i_MemRdData   (mrd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hCAFE_0005;
    mem[3] = 32'h0000_AAAA;

    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;

    // Reset state: requests ignored, no write strobe.
    req0 = 1; we0 = 1; addr0 = 12'd7;
    #2;
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_memwe", 32'(mwe), 32'd0);
    chk("rst_rv0", 32'(rv0), 32'd0);
    chk("rst_rv1", 32'(rv1), 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    req0 = 0; we0 = 0;
    tick();
    rst_n = 1'b1;

    // Single read
    req0 = 1; addr0 = 12'd5;
    #1;
    chk("sr_ready0", 32'(rdy0), 32'd1);
    chk("sr_ready1", 32'(rdy1), 32'd0);
    chk("sr_maddr", 32'(maddr), 32'd5);
    chk("sr_memwe", 32'(mwe), 32'd0);
    tick();
    req0 = 0;
    chk("sr_rv0", 32'(rv0), 32'd1);
    chk("sr_rd0", rd0, 32'hCAFE_0005);
    chk("sr_rv1", 32'(rv1), 32'd0);
    tick();
    chk("sr_rv0_drop", 32'(rv0), 32'd0);
    chk("sr_rd0_hold", rd0, 32'hCAFE_0005);

    // Contention from a fresh reset: 0,1,0,1
    rst_n = 0;
    #1;
    rst_n = 1;
    req0 = 1; addr0 = 12'd1;
    req1 = 1; addr1 = 12'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ct_ready0", 32'(rdy0), 32'((k % 2) == 0));
      chk("ct_ready1", 32'(rdy1), 32'((k % 2) == 1));
      if (k > 0) begin
        if ((k % 2) == 1) begin
          chk("ct_rv0", 32'(rv0), 32'd1);
          chk("ct_rv1", 32'(rv1), 32'd0);
          chk("ct_rd0", rd0, 32'h1000_0001);
        end else begin
          chk("ct_rv1", 32'(rv1), 32'd1);
          chk("ct_rv0", 32'(rv0), 32'd0);
          chk("ct_rd1", rd1, 32'h1000_0002);
        end
      end
      tick();
    end
    req0 = 0; req1 = 0;
    chk("ct_last_rv1", 32'(rv1), 32'd1);
    chk("ct_last_rv0", 32'(rv0), 32'd0);
    chk("ct_last_rd1", rd1, 32'h1000_0002);

    // Read-after-write, same address
    req1 = 1; we1 = 1; addr1 = 12'd9; wd1 = 32'h1234_5678;
    #1;
    chk("raw_ready1", 32'(rdy1), 32'd1);
    chk("raw_memwe", 32'(mwe), 32'd1);
    chk("raw_maddr", 32'(maddr), 32'd9);
    chk("raw_mwd", mwd, 32'h1234_5678);
    tick();
    req1 = 0; we1 = 0;
    req0 = 1; addr0 = 12'd9;
    #1;
    chk("raw_ready0", 32'(rdy0), 32'd1);
    chk("raw_memwe_rd", 32'(mwe), 32'd0);
    chk("raw_wrsp1", 32'(rv1), 32'd1);
    chk("raw_rd1_keep", rd1, 32'h1000_0002);
    tick();
    req0 = 0;
    chk("raw_rv0", 32'(rv0), 32'd1);
    chk("raw_rd0", rd0, 32'h1234_5678);
    chk("raw_rv1", 32'(rv1), 32'd0);
    #1;
    chk("raw_memwe_idle", 32'(mwe), 32'd0);

    // Write response keeps RdData; back-to-back on port 0
    tick();
    req0 = 1; addr0 = 12'd3;
    tick();
    we0 = 1; addr0 = 12'd4; wd0 = 32'h0000_5555;
    #1;
    chk("wr_ready0", 32'(rdy0), 32'd1);
    chk("wr_rv0_rd", 32'(rv0), 32'd1);
    chk("wr_rd0_rd", rd0, 32'h0000_AAAA);
    tick();
    req0 = 0; we0 = 0;
    chk("wr_rv0_wr", 32'(rv0), 32'd1);
    chk("wr_rd0_keep", rd0, 32'h0000_AAAA);
    chk("wr_mem4", mem[4], 32'h0000_5555);

    // Reset in the middle of a read
    tick();
    req0 = 1; addr0 = 12'd5;
    #1;
    chk("mr_ready0", 32'(rdy0), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("mr_ready0_rst", 32'(rdy0), 32'd0);
    req1 = 1; we1 = 1; addr1 = 12'd7; wd1 = 32'hDEAD_BEEF;
    #1;
    chk("mr_memwe_rst", 32'(mwe), 32'd0);
    tick();
    chk("mr_rv0", 32'(rv0), 32'd0);
    chk("mr_rd0", rd0, 32'd0);
    chk("mr_rd1", rd1, 32'd0);
    chk("mr_mem7", mem[7], 32'h1000_0007);
    rst_n = 1;
    we1 = 0; addr1 = 12'd2;
    #1;
    chk("mr_first0", 32'(rdy0), 32'd1);
    chk("mr_first1", 32'(rdy1), 32'd0);
    tick();
    req0 = 0; req1 = 0;
    chk("mr_rv0_post", 32'(rv0), 32'd1);
    chk("mr_rd0_post", rd0, 32'hCAFE_0005);

    // Idle for 10 cycles
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("id_memwe", 32'(mwe), 32'd0);
      chk("id_maddr", 32'(maddr), 32'd0);
      chk("id_mwd", mwd, 32'd0);
      chk("id_ready", 32'({rdy1, rdy0}), 32'd0);
      chk("id_rv", 32'({rv1, rv0}), 32'd0);
      tick();
    end

    // Pointer kept through idle: port 1 wins next contention
    req0 = 1; addr0 = 12'd1;
    req1 = 1; addr1 = 12'd2;
    #1;
    chk("id_ptr_ready1", 32'(rdy1), 32'd1);
    chk("id_ptr_ready0", 32'(rdy0), 32'd0);
    tick();
    req0 = 0; req1 = 0;
    chk("id_ptr_rv1", 32'(rv1), 32'd1);
    chk("id_ptr_rd1", rd1, 32'h1000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
